// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand-fetch / issue stage in front of a 32-bit combinational ALU.
//   Register-form instructions arrive over a valid/ready handshake, read a
//   REG_CNT x DATA_W register file (with forwarding from EX), and drive
//   registered operands into the ALU. The ALU result comes back in the same
//   cycle and is written to the register file and flags register at the end
//   of EX. There are two stages, ISSUE and EX, with no stalls.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  instruction handshake (ready = !rst && !hold)
//   hold            freeze request; blocks acceptance, EX still drains
//   in_*            opcode, rd, rs1, rs2, immediate select/value, carry use
//   alu_a/b/opcode/cin   registered operands to the ALU
//   alu_final/status     ALU result, status {V,N,C,Z}
//   wb_valid/rd/data     one-cycle writeback report
//   flags           architectural flags {V,N,C,Z}
//   dbg_addr/data   combinational register-file read port
module alu_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  input  logic [3:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_final,
  input  logic [3:0]        alu_status,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf [REG_CNT];

  // vld_pipe[0]: EX holds a real instruction; vld_pipe[1]: writeback pulse
  logic [1:0]        vld_pipe;
  logic [ADDR_W-1:0] ex_rd;

  logic              accept;
  logic              ex_op_ok;
  logic              ex_commit;
  logic              ex_fwd;
  logic [DATA_W-1:0] opa, opb;
  logic              cin;

  assign in_ready = !rst && !hold;
  assign accept   = in_valid && in_ready;

  // Opcodes 0001..0111 are real ALU ops; everything else is a NOP.
  assign ex_op_ok  = (alu_opcode != 4'd0) && !alu_opcode[3];
  assign ex_commit = vld_pipe[0] && ex_op_ok;
  // r0 writes are dropped, so they must not forward either.
  assign ex_fwd    = ex_commit && (ex_rd != '0);

  always_comb begin
    opa = rf[in_rs1];
    if (ex_fwd && (ex_rd == in_rs1)) opa = alu_final;
    if (in_rs1 == '0)                opa = '0;

    opb = rf[in_rs2];
    if (ex_fwd && (ex_rd == in_rs2)) opb = alu_final;
    if (in_rs2 == '0)                opb = '0;
    if (in_use_imm)                  opb = in_imm;

    // Flags update even for rd=0, so carry forwards on ex_commit, not ex_fwd.
    cin = in_use_carry && (ex_commit ? alu_status[1] : flags[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
      vld_pipe   <= '0;
      ex_rd      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 4'd0;
      alu_cin    <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flags      <= 4'd0;
    end else begin
      // writeback from EX
      vld_pipe[1] <= ex_commit;
      if (ex_commit) begin
        if (ex_fwd) rf[ex_rd] <= alu_final;
        flags   <= alu_status;
        wb_rd   <= ex_rd;
        wb_data <= alu_final;
      end

      // issue into EX
      vld_pipe[0] <= accept;
      if (accept) begin
        ex_rd      <= in_rd;
        alu_a      <= opa;
        alu_b      <= opb;
        alu_opcode <= in_opcode;
        alu_cin    <= cin;
      end else begin
        alu_opcode <= 4'd0;
      end
    end
  end

  assign wb_valid = vld_pipe[1];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, hold;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_imm, in_use_carry;
  logic [31:0] in_imm;
  logic [31:0] alu_a, alu_b, alu_final;
  logic [3:0]  alu_opcode, alu_status;
  logic        alu_cin;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .REG_CNT(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_use_carry(in_use_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_final(alu_final), .alu_status(alu_status),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: status = {V, N, C, Z}
  logic [32:0] sum;
  logic        c_o, v_o;
  always_comb begin
    sum       = 33'd0;
    alu_final = 32'd0;
    c_o       = 1'b0;
    v_o       = 1'b0;
    case (alu_opcode)
      4'd1: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
        alu_final = sum[31:0];
        c_o       = sum[32];
        v_o       = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'd2: alu_final = alu_a ^ alu_b;
      4'd3: alu_final = alu_a & alu_b;
      4'd4: alu_final = alu_a | alu_b;
      4'd5: alu_final = ~(alu_a | alu_b);
      4'd6: alu_final = alu_a >> alu_b[4:0];
      4'd7: alu_final = alu_a << alu_b[4:0];
      default: alu_final = 32'd0;
    endcase
    alu_status = {v_o, alu_final[31], c_o, alu_final == 32'd0};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic        use_c;
    logic [31:0] ea, eb;
    logic        ecin;
    logic        ewb;
    logic [31:0] ewd;
    logic [3:0]  efl;   // flags after this instruction completes
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, rd, rs1, rs2, input logic ui,
                              input logic [31:0] imm, input logic uc,
                              input logic [31:0] ea, eb, input logic ecin,
                              input logic ewb, input logic [31:0] ewd, input logic [3:0] efl);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.use_imm = ui; v.imm = imm;
    v.use_c = uc; v.ea = ea; v.eb = eb; v.ecin = ecin; v.ewb = ewb; v.ewd = ewd; v.efl = efl;
    return v;
  endfunction

  localparam int N = 12;
  vec_t        tbl [N];
  logic [31:0] final_rf [12];

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_use_imm = v.use_imm; in_imm = v.imm; in_use_carry = v.use_c;
  endtask

  initial begin
    //           op     rd  rs1 rs2 ui imm           uc ea            eb            cin wb  wdata         flags
    tbl[0]  = mk(4'h1,  1,  0,  0, 1, 32'd5,        0, 32'd0,        32'd5,        0, 1, 32'd5,        4'b0000);
    tbl[1]  = mk(4'h1,  2,  1,  0, 1, 32'd7,        0, 32'd5,        32'd7,        0, 1, 32'd12,       4'b0000);
    tbl[2]  = mk(4'h2,  3,  0,  0, 1, 32'hFFFFFFFF, 0, 32'd0,        32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 4'b0100);
    tbl[3]  = mk(4'h1,  4,  3,  0, 1, 32'd1,        0, 32'hFFFFFFFF, 32'd1,        0, 1, 32'd0,        4'b0011);
    tbl[4]  = mk(4'h1,  5,  0,  0, 1, 32'd0,        1, 32'd0,        32'd0,        1, 1, 32'd1,        4'b0000);
    tbl[5]  = mk(4'hA,  6,  5,  0, 1, 32'd9,        0, 32'd1,        32'd9,        0, 0, 32'd0,        4'b0000);
    tbl[6]  = mk(4'h2,  0,  1,  0, 1, 32'hA5,       0, 32'd5,        32'hA5,       0, 1, 32'hA0,       4'b0000);
    tbl[7]  = mk(4'h4,  7,  0,  2, 0, 32'd0,        0, 32'd0,        32'd12,       0, 1, 32'd12,       4'b0000);
    tbl[8]  = mk(4'h1,  8,  3,  0, 1, 32'd2,        0, 32'hFFFFFFFF, 32'd2,        0, 1, 32'd1,        4'b0010);
    tbl[9]  = mk(4'h0,  9,  8,  0, 1, 32'd0,        0, 32'd1,        32'd0,        0, 0, 32'd0,        4'b0010);
    tbl[10] = mk(4'h1, 10,  0,  0, 1, 32'd3,        1, 32'd0,        32'd3,        1, 1, 32'd4,        4'b0000);
    tbl[11] = mk(4'h6, 11, 10,  1, 0, 32'd0,        0, 32'd4,        32'd5,        0, 1, 32'd0,        4'b0001);
    final_rf = '{32'd0, 32'd5, 32'd12, 32'hFFFFFFFF, 32'd0, 32'd1,
                 32'd0, 32'd12, 32'd1, 32'd0, 32'd4, 32'd0};

    rst = 1'b1; hold = 1'b0; in_valid = 1'b0; in_opcode = 4'd0; in_rd = 4'd0;
    in_rs1 = 4'd0; in_rs2 = 4'd0; in_use_imm = 1'b0; in_imm = 32'd0;
    in_use_carry = 1'b0; dbg_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1 chk($sformatf("rst_r%0d", r), dbg_data, 32'd0);
    end
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // back-to-back stream: check operands of i and writeback of i-1
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        drive(tbl[i]);
        dbg_addr = tbl[i].rd;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i < N) begin
        chk($sformatf("v%0d_alu_a", i), alu_a, tbl[i].ea);
        chk($sformatf("v%0d_alu_b", i), alu_b, tbl[i].eb);
        chk($sformatf("v%0d_alu_cin", i), {31'd0, alu_cin}, {31'd0, tbl[i].ecin});
        chk($sformatf("v%0d_alu_op", i), {28'd0, alu_opcode}, {28'd0, tbl[i].op});
        chk($sformatf("v%0d_dbg_old", i), dbg_data, 32'd0);
      end else begin
        chk("drain_bubble_op", {28'd0, alu_opcode}, 32'd0);
      end
      if (i > 0) begin
        chk($sformatf("v%0d_wb_valid", i-1), {31'd0, wb_valid}, {31'd0, tbl[i-1].ewb});
        if (tbl[i-1].ewb) begin
          chk($sformatf("v%0d_wb_rd", i-1), {28'd0, wb_rd}, {28'd0, tbl[i-1].rd});
          chk($sformatf("v%0d_wb_data", i-1), wb_data, tbl[i-1].ewd);
        end
        chk($sformatf("v%0d_flags", i-1), {28'd0, flags}, {28'd0, tbl[i-1].efl});
      end
    end
    @(posedge clk); #1;
    chk("wb_pulse_ends", {31'd0, wb_valid}, 32'd0);
    for (int r = 0; r < 12; r++) begin
      dbg_addr = 4'(r);
      #1 chk($sformatf("final_r%0d", r), dbg_data, final_rf[r]);
    end

    // hold: in-flight op completes, nothing new accepted
    drive(mk(4'h1, 12, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("hold_acc_b", alu_b, 32'h55);
    hold = 1'b1;
    drive(mk(4'h1, 13, 0, 0, 1, 32'h66, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("hold_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("hold_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("hold_wb_rd", {28'd0, wb_rd}, 32'd12);
    chk("hold_wb_data", wb_data, 32'h55);
    chk("hold_no_issue", {28'd0, alu_opcode}, 32'd0);
    @(posedge clk); #1;
    chk("hold_no_wb", {31'd0, wb_valid}, 32'd0);
    dbg_addr = 4'd12;
    #1 chk("hold_r12", dbg_data, 32'h55);
    dbg_addr = 4'd13;
    #1 chk("hold_r13", dbg_data, 32'd0);
    hold = 1'b0;

    // reset while an op sits in EX: it must be discarded
    drive(mk(4'h1, 14, 1, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("rstex_alu_a", alu_a, 32'd5);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rstex_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dbg_addr = 4'd14;
    #1 chk("rstex_r14", dbg_data, 32'd0);
    dbg_addr = 4'd1;
    #1 chk("rstex_r1", dbg_data, 32'd0);
    chk("rstex_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstex_wb_rd", {28'd0, wb_rd}, 32'd0);
    chk("rstex_wb_data", wb_data, 32'd0);
    chk("rstex_flags", {28'd0, flags}, 32'd0);
    chk("rstex_alu_a0", alu_a, 32'd0);
    chk("rstex_alu_b0", alu_b, 32'd0);
    chk("rstex_alu_op", {28'd0, alu_opcode}, 32'd0);
    chk("rstex_alu_cin", {31'd0, alu_cin}, 32'd0);
    @(posedge clk); #1;
    chk("rstex_no_late_wb", {31'd0, wb_valid}, 32'd0);
    dbg_addr = 4'd14;
    #1 chk("rstex_r14_late", dbg_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
